// File: rtl/yannickreiss_muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// The MULDIV_EARLY_DONE_EN macro, consumed by the top, needs nothing from here.
package yannickreiss_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/yannickreiss_muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first restoring divide.
// Multiply keeps {acc, sh} as the running product; divide keeps acc = remainder, sh = dividend/quotient.
module yannickreiss_muldiv_step
    import yannickreiss_muldiv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             op_code,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] sh_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] sh_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic           fits;

    // Single shift-add or trial-subtract step selected by op_code
    always_comb begin
        sum     = {1'b0, acc_in} + (sh_in[0] ? {1'b0, op2} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_in, sh_in[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, op2});
        acc_out = acc_in;
        sh_out  = sh_in;
        if (op_code == OP_MUL) begin
            acc_out = sum[WIDTH:1];
            sh_out  = {sum[0], sh_in[WIDTH-1:1]};
        end else if (fits) begin
            // Remainder stays below op2, so the difference always fits in WIDTH bits
            acc_out = WIDTH'(rem_sh - {1'b0, op2});
            sh_out  = {sh_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = rem_sh[WIDTH-1:0];
            sh_out  = {sh_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/yannickreiss_seq_muldiv.sv
// Iterative unsigned multiply/divide unit with start/busy/done handshake.
// Define MULDIV_EARLY_DONE_EN to let trivial operands bypass the iteration phase.
module yannickreiss_seq_muldiv
    import yannickreiss_muldiv_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op_code,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic [WIDTH-1:0]   op2_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   sh_r;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   sh_step;
    logic               accept;
    logic               trivial;
    logic [2*WIDTH-1:0] triv_res;
    logic               triv_dbz;
    logic [2*WIDTH-1:0] calc_res;
    logic               calc_dbz;

    yannickreiss_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_code (op_r),
        .op2     (op2_r),
        .acc_in  (acc_r),
        .sh_in   (sh_r),
        .acc_out (acc_step),
        .sh_out  (sh_step)
    );

    // Shortcut results for operands that need no iteration
    always_comb begin
        trivial  = 1'b0;
        triv_res = ZERO_2W;
        triv_dbz = 1'b0;
`ifdef MULDIV_EARLY_DONE_EN
        if ((op1 == ZERO_W) || (op2 == ZERO_W)) begin
            trivial  = 1'b1;
            triv_dbz = (op_code == OP_DIV) && (op2 == ZERO_W);
        end else if (op2 == ONE_W) begin
            trivial  = 1'b1;
            triv_res = (op_code == OP_MUL) ? {ZERO_W, op1} : {op1, ZERO_W};
        end else if ((op_code == OP_DIV) && (op1 < op2)) begin
            trivial  = 1'b1;
            triv_res = {ZERO_W, op1};
        end else begin
            trivial  = 1'b0;
        end
`endif
    end

    // Final-iteration result; divide by zero forces an all-zero result
    always_comb begin
        calc_dbz = (op_r == OP_DIV) && (op2_r == ZERO_W);
        if (op_r == OP_MUL) begin
            calc_res = {acc_step, sh_step};
        end else if (calc_dbz) begin
            calc_res = ZERO_2W;
        end else begin
            calc_res = {sh_step, acc_step};
        end
    end

    // Next-state logic; a start seen in DONE chains straight into the next op
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = trivial ? ST_DONE : ST_CALC;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt == CNT_ONE) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_CALC;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= {CNT_W{1'b0}};
            op_r        <= OP_MUL;
            op2_r       <= ZERO_W;
            acc_r       <= ZERO_W;
            sh_r        <= ZERO_W;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= ZERO_2W;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ST_CALC);
            done  <= (state_nx == ST_DONE);
            if (accept) begin
                op_r  <= op_code;
                op2_r <= op2;
                acc_r <= ZERO_W;
                sh_r  <= op1;
                cnt   <= CNT_LOAD;
                if (trivial) begin
                    result      <= triv_res;
                    div_by_zero <= triv_dbz;
                end
            end else if (state == ST_CALC) begin
                acc_r <= acc_step;
                sh_r  <= sh_step;
                cnt   <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    result      <= calc_res;
                    div_by_zero <= calc_dbz;
                end
            end
        end
    end

endmodule

// File: tb/tb_yannickreiss_seq_muldiv.sv
// Self-checking bench: directed vector table and corner sequences at WIDTH=4,
// exhaustive WIDTH=3 and random WIDTH=8 sweeps against an arithmetic model.
module tb_yannickreiss_seq_muldiv;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       s4, o4, b4, d4, z4;
    logic [3:0] a4, c4;
    logic [7:0] r4;
    logic       s3, o3, b3, d3, z3;
    logic [2:0] a3, c3;
    logic [5:0] r3;
    logic       s8, o8, b8, d8, z8;
    logic [7:0] a8, c8;
    logic [15:0] r8;

    yannickreiss_seq_muldiv #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(s4), .op_code(o4), .op1(a4), .op2(c4),
        .busy(b4), .done(d4), .result(r4), .div_by_zero(z4));
    yannickreiss_seq_muldiv #(.WIDTH(3)) dut3 (
        .clk(clk), .reset(reset), .start(s3), .op_code(o3), .op1(a3), .op2(c3),
        .busy(b3), .done(d3), .result(r3), .div_by_zero(z3));
    yannickreiss_seq_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .op_code(o8), .op1(a8), .op2(c8),
        .busy(b8), .done(d8), .result(r8), .div_by_zero(z8));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       dbz;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input int w, input logic op, input int a, input int b);
`ifdef MULDIV_EARLY_DONE_EN
        if (a == 0 || b == 0 || b == 1 || (op && a < b)) return 0;
`endif
        return w;
    endfunction

    function automatic longint unsigned model_res(input int w, input logic op, input int a, input int b);
        longint unsigned q, r;
        if (!op) return longint'(a) * longint'(b);
        if (b == 0) return 0;
        q = a / b;
        r = a % b;
        return (q << w) | r;
    endfunction

    task automatic run4(input logic op, input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int busy_n, output bit stable);
        logic [7:0] prev;
        prev = r4;
        o4 = op; a4 = a; c4 = b; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0; o4 = 1'($urandom); a4 = 4'($urandom); c4 = 4'($urandom);
        lat = 0; busy_n = 0; stable = 1'b1;
        while (!d4 && lat < 40) begin
            if (b4) busy_n++;
            if (r4 !== prev) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run3(input logic op, input int a, input int b, output int lat);
        o3 = op; a3 = 3'(a); c3 = 3'(b); s3 = 1'b1;
        @(posedge clk); #1;
        s3 = 1'b0; a3 = 3'($urandom); c3 = 3'($urandom);
        lat = 0;
        while (!d3 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run8(input logic op, input int a, input int b, output int lat);
        o8 = op; a8 = 8'(a); c8 = 8'(b); s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0; a8 = 8'($urandom); c8 = 8'($urandom);
        lat = 0;
        while (!d8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int  lat, busy_n, n;
        bit  stable, saw;
        reset = 1'b1;
        s4 = 1'b0; o4 = 1'b0; a4 = 4'd0; c4 = 4'd0;
        s3 = 1'b0; o3 = 1'b0; a3 = 3'd0; c3 = 3'd0;
        s8 = 1'b0; o8 = 1'b0; a8 = 8'd0; c8 = 8'd0;
        vecs[0] = '{1'b0, 4'd7,  4'd6,  8'h2A, 1'b0};
        vecs[1] = '{1'b1, 4'd13, 4'd3,  8'h41, 1'b0};
        vecs[2] = '{1'b1, 4'd15, 4'd15, 8'h10, 1'b0};
        vecs[3] = '{1'b1, 4'd2,  4'd7,  8'h02, 1'b0};
        vecs[4] = '{1'b1, 4'd9,  4'd0,  8'h00, 1'b1};
        vecs[5] = '{1'b0, 4'd15, 4'd15, 8'hE1, 1'b0};
        vecs[6] = '{1'b0, 4'd0,  4'd9,  8'h00, 1'b0};
        vecs[7] = '{1'b1, 4'd8,  4'd1,  8'h80, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_busy", 64'(b4), 64'd0);
        check("reset_done", 64'(d4), 64'd0);
        check("reset_result", 64'(r4), 64'd0);
        check("reset_dbz", 64'(z4), 64'd0);
        check("reset_w3_w8", 64'({b3, d3, r3, z3, b8, d8, r8, z8}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run4(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_n, stable);
            check($sformatf("vec%0d_result", i), 64'(r4), 64'(vecs[i].res));
            check($sformatf("vec%0d_dbz", i), 64'(z4), 64'(vecs[i].dbz));
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'(exp_lat(4, vecs[i].op, int'(vecs[i].a), int'(vecs[i].b))));
            check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n),
                  64'(exp_lat(4, vecs[i].op, int'(vecs[i].a), int'(vecs[i].b))));
            check($sformatf("vec%0d_result_stable", i), 64'(stable), 64'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 64'({d4, b4}), 64'd0);
        end

        // Start during CALC is ignored; then a start in the DONE cycle chains
        o4 = 1'b0; a4 = 4'd7; c4 = 4'd6; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        @(posedge clk); #1;
        s4 = 1'b1; o4 = 1'b1; a4 = 4'd3; c4 = 4'd3;
        @(posedge clk); #1;
        s4 = 1'b0;
        n = 2;
        while (!d4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("ignored_start_latency", 64'(n), 64'd4);
        check("ignored_start_result", 64'(r4), 64'h2A);
        s4 = 1'b1; o4 = 1'b0; a4 = 4'd5; c4 = 4'd3;
        @(posedge clk); #1;
        s4 = 1'b0;
        check("b2b_busy", 64'(b4), 64'd1);
        n = 0;
        while (!d4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_latency", 64'(n), 64'd4);
        check("b2b_result", 64'(r4), 64'h0F);

        // Reset in mid-operation discards it
        @(posedge clk); #1;
        o4 = 1'b0; a4 = 4'd7; c4 = 4'd6; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_busy", 64'(b4), 64'd0);
        check("midreset_result", 64'(r4), 64'd0);
        check("midreset_done", 64'(d4), 64'd0);
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (d4 || b4) saw = 1'b1;
        end
        check("midreset_no_done", 64'(saw), 64'd0);

        // Reset and start on the same edge: reset wins
        reset = 1'b1; s4 = 1'b1; o4 = 1'b0; a4 = 4'd3; c4 = 4'd5;
        @(posedge clk); #1;
        reset = 1'b0; s4 = 1'b0;
        saw = 1'b0;
        repeat (7) begin
            if (d4 || b4) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("reset_vs_start", 64'(saw), 64'd0);
        run4(1'b1, 4'd13, 4'd3, lat, busy_n, stable);
        check("after_reset_result", 64'(r4), 64'h41);
        check("after_reset_latency", 64'(lat), 64'd4);

        // Exhaustive WIDTH=3
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    run3(1'(op), a, b, lat);
                    check($sformatf("w3_op%0d_%0d_%0d", op, a, b),
                          64'({r3, z3, 8'(lat)}),
                          64'({6'(model_res(3, 1'(op), a, b)), (op == 1 && b == 0),
                               8'(exp_lat(3, 1'(op), a, b))}));
                    @(posedge clk); #1;
                end
            end
        end

        // Random WIDTH=8
        for (int i = 0; i < 150; i++) begin
            logic op;
            int a, b;
            op = 1'($urandom);
            a  = (i % 13 == 0) ? 0 : int'($urandom_range(0, 255));
            b  = (i % 7 == 0) ? 0 : (i % 11 == 0) ? 1 : int'($urandom_range(0, 255));
            run8(op, a, b, lat);
            check($sformatf("w8_op%0d_%0d_%0d", op, a, b),
                  64'({r8, z8, 8'(lat)}),
                  64'({16'(model_res(8, op, a, b)), (op == 1'b1 && b == 0),
                       8'(exp_lat(8, op, a, b))}));
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
